mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips32_mem_pkg.sv | 15 +
 rtl/arb_starve_cnt.sv | 35 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the single-port memory arbiter: default widths,
// fairness limit default and the port-owner state encoding.
package mips32_mem_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter: counts consecutive cycles in which the fetch side
// asks for the memory and is refused while not halted, saturating at MAX_WAIT.
// Once saturated, 'starved' tells the arbiter to let fetch win over data.
module arb_starve_cnt
  import mips32_mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic halt,
  output logic starved
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  // Clear on a fetch grant or a dropped request, otherwise count refusals up to the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (if_gnt || !if_req) begin
      cnt <= '0;
    end else if (!halt && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous single-port memory between the fetch and
// data sides of the processor. Data normally wins; halt blocks new fetches.
// Build option: define MEM_ARB_FAIRNESS_EN to add the fetch starvation
// counter, which lets fetch win after MAX_WAIT consecutive refusals.
module mem_port_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_t            state, next_state;
  logic              dm_read_q, next_dm_read;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              fetch_ok;
  logic              starved;

  assign fetch_ok = if_req && !halt;

`ifdef MEM_ARB_FAIRNESS_EN
  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .halt    (halt),
    .starved (starved)
  );
`else
  // Strict data priority: fetch is never promoted (MAX_WAIT is never negative)
  assign starved = (MAX_WAIT < 0);
`endif

  // Grant decision: data first unless fetch has been starved to the limit
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (dm_req && !(fetch_ok && starved)) begin
        dm_gnt = 1'b1;
      end else if (fetch_ok) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Next owner: who used the memory this cycle, and whether data expects read data
  always_comb begin
    next_state   = IDLE;
    next_dm_read = 1'b0;
    if (dm_gnt) begin
      next_state   = DATA;
      next_dm_read = !dm_we;
    end else if (if_gnt) begin
      next_state = FETCH;
    end
  end

  // Owner register and memory address/data hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dm_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= next_state;
      dm_read_q <= next_dm_read;
      addr_q    <= mem_addr;
      wdata_q   <= mem_wdata;
    end
  end

  // Memory strobes follow the granted side and hold address/data when idle
  always_comb begin
    mem_en    = if_gnt || dm_gnt;
    mem_we    = dm_gnt && dm_we;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  assign if_rvalid = (state == FETCH);
  assign dm_rvalid = (state == DATA) && dm_read_q;
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

  // Capture returned read data so each side's rdata holds until its next rvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_rdata_q <= if_rdata;
      dm_rdata_q <= dm_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous
// memory model. Honours MEM_ARB_FAIRNESS_EN when computing expected grants.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR_ON = 1'b1;
`else
  localparam bit FAIR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        halt;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W   (10),
    .DATA_W   (32),
    .MAX_WAIT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .halt      (halt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after mem_en
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Drive one cycle of inputs at the falling edge, then settle before checking
  task automatic applyStimulus(input logic r, input logic ir, input logic [9:0] ia,
                               input logic dr, input logic dw, input logic [9:0] da,
                               input logic [31:0] dd, input logic h);
    @(negedge clk);
    rst      = r;
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_we    = dw;
    dm_addr  = da;
    dm_wdata = dd;
    halt     = h;
    #1;
  endtask

  // Compare one observed value against its expected value and count it
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5] = 32'h2842000A;
    mem[7] = 32'h12345678;
    mem[9] = 32'h00000909;

    // Reset with requests pending: no grants, cleared read side
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; halt = 1'b0;
    applyStimulus(1, 1, 10'd5, 1, 0, 10'd7, 32'h0, 0);
    checkOutput("rst_if_gnt", if_gnt, 0);
    checkOutput("rst_dm_gnt", dm_gnt, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_if_rvalid", if_rvalid, 0);
    checkOutput("rst_dm_rvalid", dm_rvalid, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_dm_rdata", dm_rdata, 0);

    // Lone fetch of address 5
    applyStimulus(0, 1, 10'd5, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("f5_if_gnt", if_gnt, 1);
    checkOutput("f5_dm_gnt", dm_gnt, 0);
    checkOutput("f5_mem_en", mem_en, 1);
    checkOutput("f5_mem_we", mem_we, 0);
    checkOutput("f5_mem_addr", mem_addr, 5);
    applyStimulus(0, 0, 10'd0, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("f5_if_rvalid", if_rvalid, 1);
    checkOutput("f5_if_rdata", if_rdata, 32'h2842000A);
    checkOutput("f5_idle_mem_en", mem_en, 0);
    checkOutput("f5_hold_addr", mem_addr, 5);
    applyStimulus(0, 0, 10'd0, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("f5_rvalid_drop", if_rvalid, 0);
    checkOutput("f5_rdata_hold", if_rdata, 32'h2842000A);

    // Contention: data read of 7 wins, fetch of 9 follows with no bubble
    applyStimulus(0, 1, 10'd9, 1, 0, 10'd7, 32'h0, 0);
    checkOutput("c_dm_gnt", dm_gnt, 1);
    checkOutput("c_if_gnt", if_gnt, 0);
    checkOutput("c_mem_addr", mem_addr, 7);
    applyStimulus(0, 1, 10'd9, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("c_dm_rvalid", dm_rvalid, 1);
    checkOutput("c_dm_rdata", dm_rdata, 32'h12345678);
    checkOutput("c_if_gnt2", if_gnt, 1);
    checkOutput("c_mem_addr2", mem_addr, 9);
    applyStimulus(0, 0, 10'd0, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("c_if_rvalid", if_rvalid, 1);
    checkOutput("c_if_rdata", if_rdata, 32'h00000909);
    checkOutput("c_dm_rvalid_drop", dm_rvalid, 0);

    // Write 0xDEADBEEF to 3, then read it back
    applyStimulus(0, 0, 10'd0, 1, 1, 10'd3, 32'hDEADBEEF, 0);
    checkOutput("w_dm_gnt", dm_gnt, 1);
    checkOutput("w_mem_we", mem_we, 1);
    checkOutput("w_mem_addr", mem_addr, 3);
    checkOutput("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 10'd0, 1, 0, 10'd3, 32'h0, 0);
    checkOutput("w_no_rvalid", dm_rvalid, 0);
    checkOutput("r_mem_we", mem_we, 0);
    checkOutput("r_dm_gnt", dm_gnt, 1);
    applyStimulus(0, 0, 10'd0, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("r_dm_rvalid", dm_rvalid, 1);
    checkOutput("r_dm_rdata", dm_rdata, 32'hDEADBEEF);
    checkOutput("r_idle_mem_we", mem_we, 0);

    // Halt: in-flight fetch completes, new fetch blocked, data still served
    applyStimulus(0, 1, 10'd5, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("h_pre_if_gnt", if_gnt, 1);
    applyStimulus(0, 1, 10'd5, 1, 0, 10'd5, 32'h0, 1);
    checkOutput("h_inflight_rvalid", if_rvalid, 1);
    checkOutput("h_inflight_rdata", if_rdata, 32'h2842000A);
    checkOutput("h_if_gnt", if_gnt, 0);
    checkOutput("h_dm_gnt", dm_gnt, 1);
    applyStimulus(0, 1, 10'd5, 0, 0, 10'd0, 32'h0, 1);
    checkOutput("h_if_gnt2", if_gnt, 0);
    checkOutput("h_dm_rvalid", dm_rvalid, 1);
    checkOutput("h_dm_rdata", dm_rdata, 32'h2842000A);
    checkOutput("h_if_rvalid_off", if_rvalid, 0);
    applyStimulus(0, 0, 10'd0, 0, 0, 10'd0, 32'h0, 0);

    // Sustained contention: fetch wins on the 4th cycle only with fairness
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 10'd5, 1, 0, 10'd7, 32'h0, 0);
      checkOutput($sformatf("fair_if_gnt_%0d", i), if_gnt, (FAIR_ON && i == 3) ? 1 : 0);
      checkOutput($sformatf("fair_dm_gnt_%0d", i), dm_gnt, (FAIR_ON && i == 3) ? 0 : 1);
    end
    applyStimulus(0, 0, 10'd0, 0, 0, 10'd0, 32'h0, 0);

    // Build up the wait count, then reset right after a read grant
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 10'd5, 1, 0, 10'd7, 32'h0, 0);
      checkOutput($sformatf("pre_rst_dm_gnt_%0d", i), dm_gnt, 1);
    end
    applyStimulus(1, 1, 10'd5, 1, 0, 10'd7, 32'h0, 0);
    checkOutput("mid_rst_dm_rvalid", dm_rvalid, 0);
    checkOutput("mid_rst_dm_gnt", dm_gnt, 0);
    checkOutput("mid_rst_if_gnt", if_gnt, 0);
    applyStimulus(0, 1, 10'd5, 1, 0, 10'd7, 32'h0, 0);
    checkOutput("post_rst_dm_rvalid", dm_rvalid, 0);
    checkOutput("post_rst_dm_rdata", dm_rdata, 0);
    checkOutput("post_rst_if_rdata", if_rdata, 0);
    checkOutput("post_rst_dm_gnt", dm_gnt, 1);
    checkOutput("post_rst_if_gnt", if_gnt, 0);
    applyStimulus(0, 0, 10'd0, 0, 0, 10'd0, 32'h0, 0);
    checkOutput("post_rst_rd_rvalid", dm_rvalid, 1);
    checkOutput("post_rst_rd_rdata", dm_rdata, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
